// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit.
// Holds the FSM state encoding, M-extension funct3 codes, the fixed
// results used for divide-by-zero / overflow, and a conditional negate.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  // Two's-complement negate when neg is set (magnitude <-> signed value).
  function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] x);
    return neg ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] x);
    return neg ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared iterative datapath (combinational).
// Multiply: acc = {hi, multiplier}; conditional add of b into hi, then
//   shift the 65-bit {carry, hi, lo} right by one.
// Divide (restoring): acc = {remainder, dividend/quotient}; shift left,
//   trial-subtract b, keep the difference when it does not borrow.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opb,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  // Compute both candidate updates and pick by operation type
  always_comb begin
    w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opb} : '0);
    w_shift = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_diff  = w_shift - {1'b0, i_opb};
    o_acc   = {w_sum, i_acc[XLEN-1:1]};
    if (i_div) begin
      if (!w_diff[XLEN]) begin
        o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      end else begin
        o_acc = {w_shift[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide responder (IDLE -> CALC -> DONE).
// Operands are latched as magnitudes plus result-sign flags; 32 iterations
// of muldiv_step produce the product or quotient/remainder, and the sign is
// applied on the final CALC cycle. Divide-by-zero and INT_MIN/-1 bypass CALC.
// Optional macro MULDIV_SEQ_FAST_MUL_EN: multiplies use a single-cycle
// 33x33 signed product and complete with latency 1.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_cnt;
  logic [2:0]          r_f3;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opb;
  logic [XLEN-1:0]     r_resp_data;

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic                w_special;
  logic [XLEN-1:0]     w_idle_data;
  logic [2*XLEN-1:0]   w_step_acc;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_calc_data;

`ifdef MULDIV_SEQ_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa;
  logic signed [XLEN:0]     w_fb;
  logic signed [2*XLEN+1:0] w_fprod;
`endif

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == DONE);
  assign resp_data  = r_resp_data;

  // Request decode: operand signedness, magnitudes and bypass results
  always_comb begin
    w_a_signed  = (req_funct3 == F3_MUL) || (req_funct3 == F3_MULH) ||
                  (req_funct3 == F3_MULHSU) || (req_funct3 == F3_DIV) ||
                  (req_funct3 == F3_REM);
    w_b_signed  = (req_funct3 == F3_MUL) || (req_funct3 == F3_MULH) ||
                  (req_funct3 == F3_DIV) || (req_funct3 == F3_REM);
    w_a_neg     = w_a_signed & req_a[XLEN-1];
    w_b_neg     = w_b_signed & req_b[XLEN-1];
    w_mag_a     = cond_neg32(w_a_neg, req_a);
    w_mag_b     = cond_neg32(w_b_neg, req_b);
    w_special   = 1'b0;
    w_idle_data = '0;
    if (req_funct3[2]) begin
      if (req_b == '0) begin
        w_special   = 1'b1;
        w_idle_data = req_funct3[1] ? req_a : DIV0_QUOTIENT;
      end else if (!req_funct3[0] && (req_a == INT_MIN) && (req_b == '1)) begin
        w_special   = 1'b1;
        w_idle_data = req_funct3[1] ? '0 : INT_MIN;
      end
    end
`ifdef MULDIV_SEQ_FAST_MUL_EN
    w_fa    = {w_a_signed & req_a[XLEN-1], req_a};
    w_fb    = {w_b_signed & req_b[XLEN-1], req_b};
    w_fprod = w_fa * w_fb;
    if (!req_funct3[2]) begin
      w_special   = 1'b1;
      w_idle_data = (req_funct3 == F3_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
    end
`endif
  end

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_div (r_f3[2]),
    .i_acc (r_acc),
    .i_opb (r_opb),
    .o_acc (w_step_acc)
  );

  // Sign fix-up and output word selection for the final iteration
  always_comb begin
    w_prod = cond_neg64(r_neg_q, w_step_acc);
    case (r_f3)
      F3_MUL:            w_calc_data = w_prod[XLEN-1:0];
      F3_DIV, F3_DIVU:   w_calc_data = cond_neg32(r_neg_q, w_step_acc[XLEN-1:0]);
      F3_REM, F3_REMU:   w_calc_data = cond_neg32(r_neg_r, w_step_acc[2*XLEN-1:XLEN]);
      default:           w_calc_data = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (r_cnt == '0) w_state_nxt = DONE;
      DONE:    if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Iteration counter and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && !flush) begin
            r_cnt <= 5'd31;
            if (w_special) r_resp_data <= w_idle_data;
          end
        end
        CALC: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == '0) r_resp_data <= w_calc_data;
        end
        default: ;
      endcase
    end
  end

  // Operand latch and per-cycle accumulator update
  always_ff @(posedge clk) begin
    if (r_state == IDLE) begin
      if (req_valid) begin
        r_f3    <= req_funct3;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_acc   <= {{XLEN{1'b0}}, w_mag_a};
        r_opb   <= w_mag_b;
      end
    end else if (r_state == CALC) begin
      r_acc <= w_step_acc;
    end
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle RV32M multiply/divide responder for the integer execute stage. Receives M-extension requests (funct3 plus two 32-bit operands) over a valid/ready handshake, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a shared iterative datapath, and returns one 32-bit result over a second valid/ready handshake. It replaces the single-cycle combinational multiply, divide and remainder paths in the ALU. The ALU keeps all RV32I operations.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  abort any in-flight operation (pipeline kill)
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_funct3  in  3  M-extension funct3: 000 MUL … 111 REMU
- req_a  in  32  rs1 value
- req_b  in  32  rs2 value
- resp_valid  out  1  result present
- resp_ready  in  1  consumer takes result
- resp_data  out  32  result

## Operation
- States: IDLE, CALC, DONE.
- Reset values (rst_n low at an edge): state IDLE, req_ready 1, resp_valid 0, resp_data 0, iteration counter 0.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch funct3, operand magnitudes and the result sign.
  - Signedness per funct3: MULH both operands signed; MULHSU a signed, b unsigned; MULHU, DIVU, REMU unsigned; MUL sign-agnostic, computed as signed.
- Special cases go IDLE→DONE directly, with no iteration:
  - DIV/DIVU with b=0: quotient 0xFFFFFFFF.
  - REM/REMU with b=0: remainder = a.
  - DIV with a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000.
  - REM with a=0x80000000, b=0xFFFFFFFF: remainder 0.
- Other requests go IDLE→CALC, counter loaded with 31.
- CALC performs one iteration per cycle:
  - multiply: shift-add into a 64-bit magnitude accumulator.
  - divide: restoring shift-subtract, producing quotient and remainder magnitudes.
- Counter decrements each CALC cycle. On the cycle where the counter is 0, the final iteration completes and the state goes to DONE.
- On the CALC→DONE edge, apply the sign and select the output word:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Signed division: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- DONE:
  - resp_valid = 1, req_ready = 0.
  - resp_data is stable until resp_valid && resp_ready; then state goes to IDLE.
- req_ready is 1 only in IDLE. No request is accepted in the same cycle as a response handshake.
- flush has priority over every transition except reset. Next state is IDLE, resp_valid 0, and a pending result is discarded. A request presented with flush high is not accepted.

## Timing
- Acceptance edge = E0.
- Iterative op: resp_valid rises after edge E0+32, i.e. 32 CALC cycles. Earliest response handshake is in the cycle after E0+32, so accept-to-result latency is 33 cycles.
- Special-case op: resp_valid is high in the cycle after E0 (latency 1).
- Back-pressure: DONE holds indefinitely while resp_ready = 0.
- Throughput: at most one request every 34 cycles for iterative ops with resp_ready tied high.
- A reset or flush asserted mid-CALC takes effect at the next edge. The counter and accumulators are then don't-care.

## Configuration
- Macro: MULDIV_SEQ_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33×33 signed combinational product. They go IDLE→DONE with latency 1, like the special cases. Division stays iterative.
- Undefined: all multiplies use the 32-iteration shift-add path (latency 33). No hardware multiplier is inferred.

## Structure
- Shared package muldiv_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - funct3 constants (F3_MUL … F3_REMU);
  - constants DIV0_QUOTIENT = 0xFFFFFFFF and INT_MIN = 0x80000000.
- One sub-module: muldiv_step. It is combinational and performs one iteration (shift-add or restoring subtract) on the {accumulator, operand} state. The FSM and counter stay in muldiv_seq.

## Test plan
- DIVU a=100, b=7, resp_ready=1 → resp_valid 33 cycles after accept, resp_data=14; REMU same operands → 2.
- DIV a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (-3); REM same → 0xFFFFFFFF (-1).
- DIV a=5, b=0 → 0xFFFFFFFF with latency 1; REM a=0x80000000, b=0xFFFFFFFF → 0, latency 1.
- MULH a=0x80000000, b=0x80000000 → 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE. Latency 33 without the macro, 1 with it.
- Back-pressure: MUL a=3, b=4 with resp_ready=0 for 10 cycles → resp_valid and resp_data=12 held stable, req_ready=0 throughout. One cycle after resp_ready=1 → IDLE.
- flush asserted at CALC cycle 10 → IDLE next cycle, no resp_valid. A fresh DIVU 9/3 then returns 3. rst_n low mid-CALC → all outputs at reset values after the edge.
